// File: rtl/dp_mem_pkg.sv
// Shared types and helpers for the pipelined dual-port memory.
// Byte grant logic resolves same-address commits from both ports.
package dp_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

  localparam int WRITE_LATENCY_MAX = 8;
  localparam int READ_LATENCY_MAX  = 8;

  // Returns {grant_b, grant_a} for one byte lane
  function automatic logic [1:0] byte_grant(
    input logic ea,
    input logic eb,
    input logic same,
    input logic b_wins
  );
    logic clash;
    clash = same & ea & eb;
    return {eb & ~(clash & ~b_wins),
            ea & ~(clash & b_wins)};
  endfunction

endpackage

// File: rtl/dual_port_memory_pipelined_rd_pipe.sv
// Per-port read pipeline: address/valid shift,
// array sample register and held output register.
module dp_mem_rd_pipe
  import dp_mem_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = 6,
  parameter int WIDTH        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_acc,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [ADDR_WIDTH-1:0] o_smp_addr,
  input  logic [WIDTH-1:0]      i_smp_data,
  output logic [WIDTH-1:0]      o_dout,
  output logic                  o_rvalid
);

  logic             smp_v;
  logic             smp_q;
  logic [WIDTH-1:0] smp_dat_q;
  logic             rvalid_q;
  logic [WIDTH-1:0] dout_q;

  if (READ_LATENCY < 1 || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad
    $error("dp_mem_rd_pipe: READ_LATENCY out of range");
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign smp_v      = i_acc;
    assign o_smp_addr = i_addr;
  end else begin : g_latn
    localparam int N = READ_LATENCY - 1;
    logic [N-1:0]                 v_q;
    logic [N-1:0][ADDR_WIDTH-1:0] a_q;

    // Carry accepted read addresses to the array sample edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        v_q <= '0;
        a_q <= '0;
      end else begin
        v_q[0] <= i_acc;
        a_q[0] <= i_addr;
        for (int i = 1; i < N; i++) begin
          v_q[i] <= v_q[i-1];
          a_q[i] <= a_q[i-1];
        end
      end
    end

    assign smp_v      = v_q[N-1];
    assign o_smp_addr = a_q[N-1];
  end

  // Sample the array, then present the word one edge later
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smp_q     <= 1'b0;
      smp_dat_q <= '0;
      rvalid_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      smp_q    <= smp_v;
      rvalid_q <= smp_q;
      if (smp_v) smp_dat_q <= i_smp_data;
      if (smp_q) dout_q    <= smp_dat_q;
    end
  end

  assign o_dout   = dout_q;
  assign o_rvalid = rvalid_q;

endmodule

// File: rtl/dual_port_memory_pipelined.sv
// True dual-port RAM with byte enables, write/read pipelines,
// collision priority and an optional post-reset clear sweep.
module dual_port_memory_pipelined
  import dp_mem_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int WRITE_LATENCY  = 1,
  parameter int READ_LATENCY_A = 2,
  parameter int READ_LATENCY_B = 2,
  parameter int B_WINS         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en_a,
  input  logic                  i_we_a,
  input  logic [WIDTH/8-1:0]    i_be_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [WIDTH-1:0]      i_din_a,
  output logic                  o_ready_a,
  output logic [WIDTH-1:0]      o_dout_a,
  output logic                  o_rvalid_a,
  input  logic                  i_en_b,
  input  logic                  i_we_b,
  input  logic [WIDTH/8-1:0]    i_be_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [WIDTH-1:0]      i_din_b,
  output logic                  o_ready_b,
  output logic [WIDTH-1:0]      o_dout_b,
  output logic                  o_rvalid_b,
  output logic                  o_init_done,
  output logic                  o_collision
);

  localparam int NB = WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NB-1:0]         be;
    logic [WIDTH-1:0]      data;
  } wr_t;

  if (WIDTH % 8 != 0 || DEPTH > 2**ADDR_WIDTH ||
      WRITE_LATENCY < 0 ||
      WRITE_LATENCY > WRITE_LATENCY_MAX) begin : g_bad
    $error("dual_port_memory_pipelined: bad parameters");
  end

  state_t          state_q;
  logic [IW-1:0]   cnt_q;
  logic            rdy_q;
  logic            coll_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  wr_t             in_a, in_b, ca, cb;
  logic            a_ok, b_ok, same, clr;
  logic [NB-1:0]   gnt_a, gnt_b;
  logic [IW-1:0]   ia, ib;

  logic [ADDR_WIDTH-1:0] sa_a, sa_b;
  logic [WIDTH-1:0]      rd_a, rd_b;

  assign clr = (state_q == ST_CLEAR);

  assign in_a = '{v: i_en_a & i_we_a & rdy_q,
                  addr: i_addr_a, be: i_be_a, data: i_din_a};
  assign in_b = '{v: i_en_b & i_we_b & rdy_q,
                  addr: i_addr_b, be: i_be_b, data: i_din_b};

  if (WRITE_LATENCY == 0) begin : g_wl0
    assign ca = in_a;
    assign cb = in_b;
  end else begin : g_wl
    wr_t [WRITE_LATENCY-1:0] pa_q, pb_q;

    // Delay accepted writes to their commit edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        pa_q <= '0;
        pb_q <= '0;
      end else begin
        pa_q[0] <= in_a;
        pb_q[0] <= in_b;
        for (int i = 1; i < WRITE_LATENCY; i++) begin
          pa_q[i] <= pa_q[i-1];
          pb_q[i] <= pb_q[i-1];
        end
      end
    end

    assign ca = pa_q[WRITE_LATENCY-1];
    assign cb = pb_q[WRITE_LATENCY-1];
  end

  assign a_ok = ca.v & ({1'b0, ca.addr} < DEPTH_W);
  assign b_ok = cb.v & ({1'b0, cb.addr} < DEPTH_W);
  assign same = a_ok & b_ok & (ca.addr == cb.addr);
  assign ia   = ca.addr[IW-1:0];
  assign ib   = cb.addr[IW-1:0];

  // Per-byte ownership of the commit, winner takes shared lanes
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int n = 0; n < NB; n++) begin
      {gnt_b[n], gnt_a[n]} = byte_grant(a_ok & ca.be[n],
                                        b_ok & cb.be[n],
                                        same,
                                        B_WINS == PRIO_B);
    end
  end

  // Array: clear sweep, else byte-lane commits from both ports
  always_ff @(posedge i_clk) begin
    if (clr) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int n = 0; n < NB; n++) begin
        if (gnt_a[n]) mem_q[ia][n*8 +: 8] <= ca.data[n*8 +: 8];
        if (gnt_b[n]) mem_q[ib][n*8 +: 8] <= cb.data[n*8 +: 8];
      end
    end
  end

  // Collision flag: overlapping lanes on a same-address commit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) coll_q <= 1'b0;
    else          coll_q <= same & (|(ca.be & cb.be));
  end

  // Clear sweep then run; ready is registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IW'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            rdy_q   <= 1'b1;
          end
        end
        ST_RUN:  rdy_q <= 1'b1;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign rd_a = ({1'b0, sa_a} < DEPTH_W) ? mem_q[sa_a[IW-1:0]] : '0;
  assign rd_b = ({1'b0, sa_b} < DEPTH_W) ? mem_q[sa_b[IW-1:0]] : '0;

  dp_mem_rd_pipe #(
    .READ_LATENCY (READ_LATENCY_A),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .WIDTH        (WIDTH)
  ) u_rd_a (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_acc      (i_en_a & ~i_we_a & rdy_q),
    .i_addr     (i_addr_a),
    .o_smp_addr (sa_a),
    .i_smp_data (rd_a),
    .o_dout     (o_dout_a),
    .o_rvalid   (o_rvalid_a)
  );

  dp_mem_rd_pipe #(
    .READ_LATENCY (READ_LATENCY_B),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .WIDTH        (WIDTH)
  ) u_rd_b (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_acc      (i_en_b & ~i_we_b & rdy_q),
    .i_addr     (i_addr_b),
    .o_smp_addr (sa_b),
    .i_smp_data (rd_b),
    .o_dout     (o_dout_b),
    .o_rvalid   (o_rvalid_b)
  );

  assign o_ready_a   = rdy_q;
  assign o_ready_b   = rdy_q;
  assign o_init_done = rdy_q;
  assign o_collision = coll_q;

endmodule

// File: tb/tb_dual_port_memory_pipelined.sv
// Bench for dual_port_memory_pipelined: two instances differing
// only in collision priority, checked against a queue-based model.
module tb_dual_port_memory_pipelined;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [6:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic        rdy_a0, rdy_b0, rv_a0, rv_b0, done0, coll0;
  logic        rdy_a1, rdy_b1, rv_a1, rv_b1, done1, coll1;
  logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;

  always #5 clk = ~clk;

  dual_port_memory_pipelined #(
    .WIDTH(32), .ADDR_WIDTH(7), .DEPTH(64), .WRITE_LATENCY(1),
    .READ_LATENCY_A(2), .READ_LATENCY_B(2), .B_WINS(0),
    .CLEAR_ON_RESET(1)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_en_a(en_a), .i_we_a(we_a), .i_be_a(be_a),
    .i_addr_a(addr_a), .i_din_a(din_a),
    .o_ready_a(rdy_a0), .o_dout_a(dout_a0), .o_rvalid_a(rv_a0),
    .i_en_b(en_b), .i_we_b(we_b), .i_be_b(be_b),
    .i_addr_b(addr_b), .i_din_b(din_b),
    .o_ready_b(rdy_b0), .o_dout_b(dout_b0), .o_rvalid_b(rv_b0),
    .o_init_done(done0), .o_collision(coll0)
  );

  dual_port_memory_pipelined #(
    .WIDTH(32), .ADDR_WIDTH(7), .DEPTH(64), .WRITE_LATENCY(1),
    .READ_LATENCY_A(2), .READ_LATENCY_B(2), .B_WINS(1),
    .CLEAR_ON_RESET(1)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_en_a(en_a), .i_we_a(we_a), .i_be_a(be_a),
    .i_addr_a(addr_a), .i_din_a(din_a),
    .o_ready_a(rdy_a1), .o_dout_a(dout_a1), .o_rvalid_a(rv_a1),
    .i_en_b(en_b), .i_we_b(we_b), .i_be_b(be_b),
    .i_addr_b(addr_b), .i_din_b(din_b),
    .o_ready_b(rdy_b1), .o_dout_b(dout_b1), .o_rvalid_b(rv_b1),
    .o_init_done(done1), .o_collision(coll1)
  );

  // Reference model: words per priority, pending ops by cycle
  typedef struct {
    int          k;
    int          addr;
    logic [31:0] d0;
    logic [31:0] d1;
  } rd_t;

  typedef struct {
    int          due;
    bit          pb;
    int          addr;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int          addr;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic [31:0] d2;
    logic [3:0]  be2;
    logic [31:0] exp;
  } be_vec_t;

  logic [31:0] m0 [64];
  logic [31:0] m1 [64];
  rd_t  rqa[$], rqb[$];
  wr_t  wq[$];
  int   t;
  logic [31:0] xa0, xa1, xb0, xb1;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  function automatic logic [31:0] rdw(bit sel, int a);
    if (a >= 64) return '0;
    return sel ? m1[a] : m0[a];
  endfunction

  function automatic void apply(bit sel, wr_t w);
    if (w.addr >= 64) return;
    for (int n = 0; n < 4; n++) begin
      if (w.be[n]) begin
        if (sel) m1[w.addr][n*8 +: 8] = w.d[n*8 +: 8];
        else     m0[w.addr][n*8 +: 8] = w.d[n*8 +: 8];
      end
    end
  endfunction

  task automatic drv_a(bit en, bit we, logic [3:0] be, int a, logic [31:0] d);
    en_a = en; we_a = we; be_a = be; addr_a = 7'(a); din_a = d;
  endtask

  task automatic drv_b(bit en, bit we, logic [3:0] be, int a, logic [31:0] d);
    en_b = en; we_b = we; be_b = be; addr_b = 7'(a); din_b = d;
  endtask

  task automatic idle();
    drv_a(0, 0, 4'h0, 0, 32'h0);
    drv_b(0, 0, 4'h0, 0, 32'h0);
  endtask

  // One clock edge: advance the model, then compare both DUTs
  task automatic step();
    bit   rdy, ea, eb, ha, hb, col;
    wr_t  wa, wb, w;
    rd_t  r;
    rdy = (t >= 64);
    @(posedge clk);
    #1;
    t++;
    ea = 0; eb = 0; ha = 0; hb = 0;
    wa = '{default: 0};
    wb = '{default: 0};
    if (rqa.size() > 0 && rqa[0].k + 2 == t) begin
      r = rqa.pop_front(); ea = 1; xa0 = r.d0; xa1 = r.d1;
    end
    if (rqb.size() > 0 && rqb[0].k + 2 == t) begin
      r = rqb.pop_front(); eb = 1; xb0 = r.d0; xb1 = r.d1;
    end
    foreach (rqa[i]) if (rqa[i].k + 1 == t) begin
      rqa[i].d0 = rdw(0, rqa[i].addr);
      rqa[i].d1 = rdw(1, rqa[i].addr);
    end
    foreach (rqb[i]) if (rqb[i].k + 1 == t) begin
      rqb[i].d0 = rdw(0, rqb[i].addr);
      rqb[i].d1 = rdw(1, rqb[i].addr);
    end
    while (wq.size() > 0 && wq[0].due == t) begin
      w = wq.pop_front();
      if (w.pb) begin wb = w; hb = 1; end
      else begin wa = w; ha = 1; end
    end
    col = ha && hb && wa.addr == wb.addr && wa.addr < 64 &&
          (wa.be & wb.be) != 0;
    // winner's bytes are applied last
    if (hb) apply(0, wb);
    if (ha) apply(0, wa);
    if (ha) apply(1, wa);
    if (hb) apply(1, wb);
    if (rdy && en_a) begin
      if (we_a) wq.push_back('{t + 1, 0, int'(addr_a), be_a, din_a});
      else      rqa.push_back('{t, int'(addr_a), '0, '0});
    end
    if (rdy && en_b) begin
      if (we_b) wq.push_back('{t + 1, 1, int'(addr_b), be_b, din_b});
      else      rqb.push_back('{t, int'(addr_b), '0, '0});
    end
    chk("ready_a0", rdy_a0, 32'(t >= 64));
    chk("ready_b0", rdy_b0, 32'(t >= 64));
    chk("done0",    done0,  32'(t >= 64));
    chk("ready_a1", rdy_a1, 32'(t >= 64));
    chk("done1",    done1,  32'(t >= 64));
    chk("rv_a0",    rv_a0,  32'(ea));
    chk("rv_b0",    rv_b0,  32'(eb));
    chk("rv_a1",    rv_a1,  32'(ea));
    chk("rv_b1",    rv_b1,  32'(eb));
    chk("dout_a0",  dout_a0, xa0);
    chk("dout_b0",  dout_b0, xb0);
    chk("dout_a1",  dout_a1, xa1);
    chk("dout_b1",  dout_b1, xb1);
    chk("coll0",    coll0,  32'(col));
    chk("coll1",    coll1,  32'(col));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready_a", rdy_a0, 0);
    chk("rst_done",    done0,  0);
    chk("rst_rv_a",    rv_a0,  0);
    chk("rst_rv_b",    rv_b1,  0);
    chk("rst_dout_a",  dout_a0, 0);
    chk("rst_dout_b",  dout_b1, 0);
    chk("rst_coll",    coll0,  0);
    rqa.delete(); rqb.delete(); wq.delete();
    for (int i = 0; i < 64; i++) begin m0[i] = '0; m1[i] = '0; end
    t = 0;
    xa0 = '0; xa1 = '0; xb0 = '0; xb1 = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sweep();
    for (int i = 0; i < 63; i++) step();
    chk("clr_rdy_63", rdy_a0, 0);
    step();
    chk("clr_rdy_64", rdy_a0, 1);
    chk("clr_rdyb_64", rdy_b1, 1);
    chk("clr_done_64", done0, 1);
  endtask

  task automatic rd_chk(bit pb, string nm, int a,
                        logic [31:0] e0, logic [31:0] e1);
    idle();
    if (pb) drv_b(1, 0, 4'h0, a, 32'h0);
    else    drv_a(1, 0, 4'h0, a, 32'h0);
    step();
    idle();
    step();
    step();
    chk({nm, "_rv"}, pb ? rv_b0 : rv_a0, 1);
    chk({nm, "_d0"}, pb ? dout_b0 : dout_a0, e0);
    chk({nm, "_d1"}, pb ? dout_b1 : dout_a1, e1);
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 71);
    return $urandom_range(0, 7);
  endfunction

  be_vec_t tbl [6];

  initial begin
    tbl[0] = '{7,  32'hAABBCCDD, 4'hF, 32'h11223344, 4'b0101, 32'hAA22CC44};
    tbl[1] = '{12, 32'h01234567, 4'hF, 32'hFFFFFFFF, 4'b0000, 32'h01234567};
    tbl[2] = '{20, 32'h00000000, 4'hF, 32'h89ABCDEF, 4'b1000, 32'h89000000};
    tbl[3] = '{33, 32'hCAFEF00D, 4'h3, 32'h12345678, 4'b1100, 32'h1234F00D};
    tbl[4] = '{63, 32'hFFFFFFFF, 4'hF, 32'h00000000, 4'b1010, 32'h00FF00FF};
    tbl[5] = '{0,  32'h5A5A5A5A, 4'hF, 32'hA5A5A5A5, 4'b0001, 32'h5A5A5AA5};

    idle();
    do_reset();
    sweep();

    rd_chk(0, "clr_rd5", 5, 32'h0, 32'h0);

    // write at k, B reads at k (old) and k+1 (new)
    drv_a(1, 1, 4'hF, 3, 32'hDEADBEEF);
    drv_b(1, 0, 4'h0, 3, 32'h0);
    step();
    drv_a(0, 0, 4'h0, 0, 32'h0);
    step();
    chk("rdw_early_rv", rv_b0, 0);
    idle();
    step();
    chk("rdw_old_rv", rv_b0, 1);
    chk("rdw_old", dout_b0, 32'h0);
    step();
    chk("rdw_new_rv", rv_b0, 1);
    chk("rdw_new", dout_b0, 32'hDEADBEEF);
    step();
    chk("rdw_hold_rv", rv_b0, 0);
    chk("rdw_hold", dout_b0, 32'hDEADBEEF);

    for (int i = 0; i < 6; i++) begin
      idle();
      drv_a(1, 1, tbl[i].be1, tbl[i].addr, tbl[i].d1);
      step();
      idle();
      drv_b(1, 1, tbl[i].be2, tbl[i].addr, tbl[i].d2);
      step();
      rd_chk(0, $sformatf("be%0d", i), tbl[i].addr,
             tbl[i].exp, tbl[i].exp);
    end

    // same-edge dual write; byte 1 is shared, bytes 0/2 are not
    drv_a(1, 1, 4'b0011, 9, 32'h000000FF);
    drv_b(1, 1, 4'b0110, 9, 32'h0000FF00);
    step();
    idle();
    step();
    chk("coll_pulse0", coll0, 1);
    chk("coll_pulse1", coll1, 1);
    step();
    chk("coll_end0", coll0, 0);
    rd_chk(0, "coll_rd", 9, 32'h000000FF, 32'h0000FFFF);

    // distinct addresses on one edge do not interact
    drv_a(1, 1, 4'hF, 10, 32'h10101010);
    drv_b(1, 1, 4'hF, 11, 32'h11111111);
    step();
    idle();
    step();
    chk("nocoll", coll0, 0);
    rd_chk(0, "dist_a", 10, 32'h10101010, 32'h10101010);
    rd_chk(1, "dist_b", 11, 32'h11111111, 32'h11111111);

    // out-of-range: reads give 0, writes vanish (6 = 70 mod 64)
    rd_chk(1, "oor_rd", 70, 32'h0, 32'h0);
    drv_a(1, 1, 4'hF, 70, 32'hFFFFFFFF);
    step();
    idle();
    step();
    rd_chk(0, "oor_alias", 6, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      drv_a(1, 0, 4'h0, i, 32'h0);
      drv_b(1, 0, 4'h0, 63 - i, 32'h0);
      step();
    end
    idle();
    repeat (3) step();

    for (int c = 0; c < 600; c++) begin
      drv_a($urandom_range(0, 1), $urandom_range(0, 1),
            4'($urandom), pick_addr(), $urandom);
      drv_b($urandom_range(0, 1), $urandom_range(0, 1),
            4'($urandom), pick_addr(), $urandom);
      if ($urandom_range(0, 3) == 0) addr_b = addr_a;
      step();
    end

    // reset with three reads and one write in flight
    drv_a(1, 0, 4'h0, 1, 32'h0);
    drv_b(1, 0, 4'h0, 2, 32'h0);
    step();
    drv_a(1, 0, 4'h0, 3, 32'h0);
    drv_b(1, 1, 4'hF, 2, 32'h12345678);
    step();
    do_reset();
    chk("mid_rst_rdy", rdy_b0, 0);
    sweep();
    rd_chk(0, "mid_rst_w", 2, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
